// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//    Stall / bubble / flush / multdiv sequencing for the five-stage pipeline.
//    Covers hazards that bypassing cannot resolve: load-use, taken branches
//    and multi-cycle multiply/divide.
//    Optional build macro: HAZARD_MD_TIMEOUT_EN. When defined, a watchdog
//    forces BUSY -> DONE once mdCycles reaches 40 without multdivReady.
module pipeline_hazard_ctrl (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] decodeIR,
   input  logic [31:0] executeIR,
   input  logic        branchTaken,
   input  logic        multdivReady,
   output logic        stallFD,
   output logic        stallDX,
   output logic        bubbleXM,
   output logic        bubbleDX,
   output logic        flushFD,
   output logic        multdivStart,
   output logic        multdivResultSel,
   output logic [5:0]  mdCycles
);

   localparam logic [4:0] OP_ALU  = 5'b00000;
   localparam logic [4:0] OP_BNE  = 5'b00010;
   localparam logic [4:0] OP_JR   = 5'b00100;
   localparam logic [4:0] OP_BLT  = 5'b00110;
   localparam logic [4:0] OP_SW   = 5'b00111;
   localparam logic [4:0] OP_LW   = 5'b01000;
   localparam logic [4:0] ALU_MUL = 5'b00110;
   localparam logic [4:0] ALU_DIV = 5'b00111;
   localparam logic [5:0] MD_MAX  = 6'd63;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } md_state_t;

   md_state_t  state_q, state_d;
   logic [5:0] md_cycles_q, md_cycles_d;

   // Instruction fields
   logic [4:0] dec_op, dec_rd, dec_rs, dec_rt;
   logic [4:0] ex_op, ex_rd, ex_aluop;
   logic       ex_is_lw, ex_is_md;
   logic [4:0] src_a, src_b;
   logic       use_a, use_b;
   logic       load_use;
   logic       md_timeout;

   assign dec_op   = decodeIR[31:27];
   assign dec_rd   = decodeIR[26:22];
   assign dec_rs   = decodeIR[21:17];
   assign dec_rt   = decodeIR[16:12];
   assign ex_op    = executeIR[31:27];
   assign ex_rd    = executeIR[26:22];
   assign ex_aluop = executeIR[6:2];

   assign ex_is_lw = (ex_op == OP_LW);
   assign ex_is_md = (ex_op == OP_ALU) && ((ex_aluop == ALU_MUL) || (ex_aluop == ALU_DIV));

   // Bits of the instruction words this block never looks at
   logic unused_ir_bits;
   assign unused_ir_bits = ^{decodeIR[11:0], executeIR[21:7], executeIR[1:0]};

   // Pick the decode-stage source registers; sw data (rd) is bypassed at dmem
   always_comb begin
      src_a = dec_rs;
      src_b = dec_rt;
      use_a = 1'b1;
      use_b = 1'b1;
      case (dec_op)
         OP_SW: begin
            src_a = dec_rs;
            use_b = 1'b0;
         end
         OP_BNE, OP_BLT, OP_JR: begin
            src_a = dec_rd;
            src_b = dec_rs;
         end
         default: ;
      endcase
   end

   assign load_use = ex_is_lw && (ex_rd != 5'd0) &&
                     ((use_a && (src_a == ex_rd)) || (use_b && (src_b == ex_rd)));

`ifdef HAZARD_MD_TIMEOUT_EN
   assign md_timeout = (md_cycles_q == 6'd40);
`else
   assign md_timeout = 1'b0;
`endif

   // Multdiv FSM next state, cycle counter and all pipeline control outputs
   always_comb begin
      state_d          = state_q;
      md_cycles_d      = md_cycles_q;
      stallFD          = 1'b0;
      stallDX          = 1'b0;
      bubbleXM         = 1'b0;
      bubbleDX         = 1'b0;
      flushFD          = 1'b0;
      multdivStart     = 1'b0;
      multdivResultSel = 1'b0;

      case (state_q)
         IDLE: begin
            if (ex_is_md) begin
               multdivStart = 1'b1;
               state_d      = BUSY;
               md_cycles_d  = 6'd1;
            end
            // A taken branch squashes the dependent instruction, so no stall
            if (branchTaken) begin
               flushFD  = 1'b1;
               bubbleDX = 1'b1;
            end else if (load_use) begin
               stallFD  = 1'b1;
               bubbleDX = 1'b1;
            end
         end
         BUSY: begin
            stallFD  = 1'b1;
            stallDX  = 1'b1;
            bubbleXM = 1'b1;
            if (multdivReady || md_timeout) begin
               state_d = DONE;
            end else if (md_cycles_q != MD_MAX) begin
               md_cycles_d = md_cycles_q + 6'd1;
            end
         end
         DONE: begin
            // executeIR still holds the mul/div here; it must not restart
            multdivResultSel = 1'b1;
            state_d          = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Everything is quiet while reset is held, whatever the inputs say
      if (reset) begin
         stallFD          = 1'b0;
         stallDX          = 1'b0;
         bubbleXM         = 1'b0;
         bubbleDX         = 1'b0;
         flushFD          = 1'b0;
         multdivStart     = 1'b0;
         multdivResultSel = 1'b0;
      end
   end

   // State and cycle-count registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         md_cycles_q <= 6'd0;
      end else begin
         state_q     <= state_d;
         md_cycles_q <= md_cycles_d;
      end
   end

   assign mdCycles = md_cycles_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

   logic        clock;
   logic        reset;
   logic [31:0] decodeIR;
   logic [31:0] executeIR;
   logic        branchTaken;
   logic        multdivReady;
   logic        stallFD, stallDX, bubbleXM, bubbleDX, flushFD;
   logic        multdivStart, multdivResultSel;
   logic [5:0]  mdCycles;

   int total = 0;
   int bad   = 0;
   int md_exp = 0;

`ifdef HAZARD_MD_TIMEOUT_EN
   localparam int TO = 40;
`else
   localparam int TO = 0;
`endif

   pipeline_hazard_ctrl dut (
      .clock            (clock),
      .reset            (reset),
      .decodeIR         (decodeIR),
      .executeIR        (executeIR),
      .branchTaken      (branchTaken),
      .multdivReady     (multdivReady),
      .stallFD          (stallFD),
      .stallDX          (stallDX),
      .bubbleXM         (bubbleXM),
      .bubbleDX         (bubbleDX),
      .flushFD          (flushFD),
      .multdivStart     (multdivStart),
      .multdivResultSel (multdivResultSel),
      .mdCycles         (mdCycles)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] enc(input logic [4:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] alu);
      return {op, rd, rs, rt, 5'd0, alu, 2'b00};
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [4:0] ops [8];
      logic [31:0] w;
      ops = '{5'b00000, 5'b00010, 5'b00100, 5'b00110, 5'b00111, 5'b01000, 5'b00101, 5'b01000};
      w = $urandom;
      w[31:27] = ops[$urandom_range(0, 7)];
      w[26:22] = 5'($urandom_range(0, 3));
      w[21:17] = 5'($urandom_range(0, 3));
      w[16:12] = 5'($urandom_range(0, 3));
      return w;
   endfunction

   // Random instruction that is never a mul/div
   function automatic logic [31:0] rand_nomd();
      logic [31:0] w;
      w = rand_instr();
      if (w[31:27] == 5'b00000 && (w[6:2] == 5'b00110 || w[6:2] == 5'b00111))
         w[6:2] = 5'b00000;
      return w;
   endfunction

   // Load-use rule: collect the registers the decode instruction reads, then
   // see whether the load in execute writes any of them
   function automatic logic ref_load_use(input logic [31:0] d, input logic [31:0] x);
      int reads[$];
      int dest;
      if (x[31:27] != 5'b01000) return 1'b0;
      dest = int'(x[26:22]);
      if (dest == 0) return 1'b0;
      case (d[31:27])
         5'b00111: reads.push_back(int'(d[21:17]));
         5'b00010, 5'b00110, 5'b00100: begin
            reads.push_back(int'(d[26:22]));
            reads.push_back(int'(d[21:17]));
         end
         default: begin
            reads.push_back(int'(d[21:17]));
            reads.push_back(int'(d[16:12]));
         end
      endcase
      foreach (reads[i]) if (reads[i] == dest) return 1'b1;
      return 1'b0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Control vector order: stallFD stallDX bubbleXM bubbleDX flushFD start sel
   task automatic chk_all(input string tag, input logic [6:0] exp_ctl, input int exp_md);
      chk({tag, "_ctl"}, {25'd0, stallFD, stallDX, bubbleXM, bubbleDX, flushFD,
                          multdivStart, multdivResultSel}, {25'd0, exp_ctl});
      chk({tag, "_md"}, {26'd0, mdCycles}, 32'(exp_md));
      $display("step %-10s ctl=%07b md=%0d", tag,
               {stallFD, stallDX, bubbleXM, bubbleDX, flushFD, multdivStart, multdivResultSel},
               mdCycles);
   endtask

   // Pipeline outside any multdiv operation (execute holds no mul/div)
   task automatic chk_idle(input string tag);
      logic lu;
      lu = ref_load_use(decodeIR, executeIR);
      chk_all(tag, {lu & ~branchTaken, 1'b0, 1'b0, lu | branchTaken, branchTaken, 1'b0, 1'b0},
              md_exp);
   endtask

   // One multdiv operation: ready arrives n_ready cycles after the start
   // pulse; a nonzero n_to is a watchdog limit on mdCycles
   task automatic run_md(input int n_ready, input int n_to, input bit is_div);
      int d;
      d = (n_to > 0 && n_to < n_ready) ? n_to : n_ready;
      @(negedge clock);
      executeIR    = enc(5'b00000, 5'd5, 5'd1, 5'd2, is_div ? 5'b00111 : 5'b00110);
      decodeIR     = rand_instr();
      branchTaken  = 1'b0;
      multdivReady = 1'($urandom);
      #1 chk_all("md_start", 7'b0000010, md_exp);
      md_exp = 1;
      for (int k = 1; k <= d; k++) begin
         @(negedge clock);
         decodeIR     = rand_instr();
         branchTaken  = 1'($urandom);
         multdivReady = (k == n_ready);
         #1 chk_all("md_busy", 7'b1110000, (k > 63) ? 63 : k);
      end
      md_exp = (d > 63) ? 63 : d;
      @(negedge clock);
      decodeIR     = rand_instr();
      branchTaken  = 1'($urandom);
      multdivReady = 1'($urandom);
      #1 chk_all("md_done", 7'b0000001, md_exp);
      @(negedge clock);
      executeIR    = rand_nomd();
      decodeIR     = rand_instr();
      branchTaken  = 1'($urandom);
      multdivReady = 1'($urandom);
      #1 chk_idle("md_after");
   endtask

   initial begin
      clock        = 1'b0;
      reset        = 1'b1;
      decodeIR     = 32'd0;
      executeIR    = enc(5'b00000, 5'd5, 5'd1, 5'd2, 5'b00110);
      branchTaken  = 1'b1;
      multdivReady = 1'b0;

      // Reset: outputs silent even with a mul and a branch on the inputs
      @(negedge clock);
      #1 chk_all("reset", 7'b0, 0);
      @(negedge clock);
      reset       = 1'b0;
      executeIR   = 32'd0;
      branchTaken = 1'b0;
      #1 chk_idle("post_rst");

      // lw $3,0($1) in execute, add $4,$3,$2 in decode
      @(negedge clock);
      executeIR = enc(5'b01000, 5'd3, 5'd1, 5'd0, 5'd0);
      decodeIR  = enc(5'b00000, 5'd4, 5'd3, 5'd2, 5'd0);
      #1 chk_all("lu_add", 7'b1001000, 0);
      @(negedge clock);
      executeIR = 32'd0;
      #1 chk_all("lu_after", 7'b0000000, 0);

      // lw $0 never stalls
      @(negedge clock);
      executeIR = enc(5'b01000, 5'd0, 5'd1, 5'd0, 5'd0);
      decodeIR  = enc(5'b00000, 5'd4, 5'd0, 5'd0, 5'd0);
      #1 chk_all("lu_r0", 7'b0000000, 0);

      // sw data register does not count, address register does
      @(negedge clock);
      executeIR = enc(5'b01000, 5'd3, 5'd1, 5'd0, 5'd0);
      decodeIR  = enc(5'b00111, 5'd3, 5'd5, 5'd0, 5'd0);
      #1 chk_all("sw_data", 7'b0000000, 0);
      @(negedge clock);
      decodeIR  = enc(5'b00111, 5'd6, 5'd3, 5'd0, 5'd0);
      #1 chk_all("sw_addr", 7'b1001000, 0);

      // bne reads rd and rs
      @(negedge clock);
      decodeIR  = enc(5'b00010, 5'd3, 5'd7, 5'd0, 5'd0);
      #1 chk_all("bne_rd", 7'b1001000, 0);

      // Branch wins over load-use
      @(negedge clock);
      decodeIR    = enc(5'b00000, 5'd4, 5'd3, 5'd2, 5'd0);
      branchTaken = 1'b1;
      #1 chk_all("br_lu", 7'b0001100, 0);
      @(negedge clock);
      branchTaken = 1'b0;
      executeIR   = 32'd0;
      #1 chk_all("br_after", 7'b0000000, 0);

      // Randomized hazard traffic
      for (int i = 0; i < 120; i++) begin
         @(negedge clock);
         executeIR    = rand_nomd();
         decodeIR     = rand_instr();
         branchTaken  = ($urandom_range(0, 3) == 0);
         multdivReady = 1'($urandom);
         #1 chk_idle("rand");
      end

      // Multdiv: ready 17 cycles after start, then random lengths
      run_md(17, TO, 1'b0);
      for (int i = 0; i < 4; i++) run_md($urandom_range(1, 30), TO, 1'($urandom));

      // Long operation: saturates at 63, or the watchdog fires at 40
      run_md(70, TO, 1'b0);

      // Reset in BUSY
      @(negedge clock);
      executeIR    = enc(5'b00000, 5'd5, 5'd1, 5'd2, 5'b00111);
      branchTaken  = 1'b0;
      multdivReady = 1'b0;
      #1 chk_all("rb_start", 7'b0000010, md_exp);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clock);
         #1 chk_all("rb_busy", 7'b1110000, k);
      end
      @(negedge clock);
      reset = 1'b1;
      #1 chk_all("rb_reset", 7'b0000000, 0);
      md_exp = 0;
      @(negedge clock);
      #1 chk_all("rb_hold", 7'b0000000, 0);
      @(negedge clock);
      reset     = 1'b0;
      executeIR = 32'd0;
      #1 chk_all("rb_idle", 7'b0000000, 0);
      run_md(3, TO, 1'b1);

      // More random traffic after the multdiv activity
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         executeIR    = rand_nomd();
         decodeIR     = rand_instr();
         branchTaken  = ($urandom_range(0, 3) == 0);
         multdivReady = 1'($urandom);
         #1 chk_idle("rand2");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
